// File: rtl/sd_pkg.sv
// Shared definitions for the SD DAT0 data-line engines (writer and reader).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sd_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_START,
    ST_DATA,
    ST_CRC,
    ST_END,
    ST_TOKEN_WAIT,
    ST_TOKEN,
    ST_BUSY_WAIT,
    ST_FIN
  } wrState_t;

  // CRC status token values returned by the card after a data block
  localparam logic [2:0] TOK_ACCEPT  = 3'b010;
  localparam logic [2:0] TOK_CRC_ERR = 3'b101;
  localparam logic [2:0] TOK_WR_ERR  = 3'b110;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int          BLOCK_LEN  = 512;
  localparam int          BLOCK_BITS = BLOCK_LEN * 8;

  // One serial step of CRC16-CCITT, data fed MSB first
  function automatic logic [15:0] crc16Step(input logic [15:0] crc, input logic bitIn);
    logic fb;
    fb = crc[15] ^ bitIn;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Serial CRC16-CCITT (x^16+x^12+x^5+1, init 0) over a bit stream, one bit per enabled clk.
// Latency: crc includes a bit on the clk after it is presented with en=1.
// Backpressure: none; en is honoured every clk and clear takes priority over en.
module sd_crc16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  // CRC shift register: clear restarts the block, en folds in one bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc <= 16'h0000;
    end else if (clear) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= crc16Step(crc, din);
    end
  end

endmodule

// File: rtl/sd_block_writer.sv
// DAT0 transmit engine for one 512-byte SD write block: preamble, start, data, CRC16, end, token, busy.
// Latency: DAT0 changes only on sdclk_fall clks; done pulses one clk after the FIN state.
// Backpressure: none; start is ignored while busy, byte buffer must return data one clk after byte_rd.
module sd_block_writer
  import sd_pkg::*;
#(
  parameter int PRE_BITS      = 8,
  parameter int TOKEN_TIMEOUT = 16,
  parameter int BUSY_TIMEOUT  = 1048575,
  parameter int BUSY_CNT_W    = 20
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sdclk_fall,
  input  logic       sdclk_rise,
  input  logic       start,
  output logic [8:0] byte_addr,
  output logic       byte_rd,
  input  logic [7:0] byte_in,
  output logic       dat0_o,
  output logic       dat0_oe,
  input  logic       dat0_i,
  output logic       busy,
  output logic       done,
  output logic [2:0] token,
  output logic       accepted,
  output logic       timeout
);

  localparam logic [11:0]           PRE_LAST  = 12'(PRE_BITS - 1);
  localparam logic [11:0]           DATA_LAST = 12'(BLOCK_BITS - 1);
  localparam logic [11:0]           TOK_LAST  = 12'(TOKEN_TIMEOUT - 1);
  localparam logic [8:0]            BYTE_LAST = 9'(BLOCK_LEN - 1);
  localparam logic [BUSY_CNT_W-1:0] BUSY_LAST = BUSY_CNT_W'(BUSY_TIMEOUT - 1);

  wrState_t              state;
  wrState_t              stateNext;
  logic [11:0]           cnt;
  logic [BUSY_CNT_W-1:0] busyCnt;
  logic [7:0]            shiftReg;
  logic [7:0]            prefetch;
  logic                  rdPend;
  logic [15:0]           crc;
  logic                  loadByte;
  logic [8:0]            byteIdx;
  logic                  dataBit;

  // Bit position within the data phase: byte index and first-bit-of-byte flag
  assign byteIdx  = cnt[11:3];
  assign loadByte = (cnt[2:0] == 3'd0);
  assign dataBit  = loadByte ? prefetch[7] : shiftReg[7];

  sd_crc16 u_crc (
    .clk  (clk),
    .rstn (rstn),
    .clear(state == ST_IDLE),
    .en   ((state == ST_DATA) && sdclk_fall),
    .din  (dataBit),
    .crc  (crc)
  );

  // Next-state decode: transmit phases advance on fall strobes, receive phases on rise strobes
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:       if (start) stateNext = ST_PRE;
      ST_PRE:        if (sdclk_fall && cnt == PRE_LAST) stateNext = ST_START;
      ST_START:      if (sdclk_fall) stateNext = ST_DATA;
      ST_DATA:       if (sdclk_fall && cnt == DATA_LAST) stateNext = ST_CRC;
      ST_CRC:        if (sdclk_fall && cnt == 12'd15) stateNext = ST_END;
      ST_END:        if (sdclk_fall) stateNext = ST_TOKEN_WAIT;
      ST_TOKEN_WAIT: begin
        if (sdclk_rise && !dat0_i)                stateNext = ST_TOKEN;
        else if (sdclk_rise && cnt == TOK_LAST)   stateNext = ST_FIN;
      end
      // three token bits, then the token end bit is skipped
      ST_TOKEN:      if (sdclk_rise && cnt == 12'd3) stateNext = ST_BUSY_WAIT;
      ST_BUSY_WAIT:  if (sdclk_rise && (dat0_i || busyCnt == BUSY_LAST)) stateNext = ST_FIN;
      ST_FIN:        stateNext = ST_IDLE;
      default:       stateNext = ST_IDLE;
    endcase
  end

  // State register plus per-state datapath: pad drive, byte prefetch, token capture, status
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      busyCnt   <= '0;
      shiftReg  <= '0;
      prefetch  <= '0;
      rdPend    <= 1'b0;
      byte_addr <= '0;
      byte_rd   <= 1'b0;
      dat0_o    <= 1'b1;
      dat0_oe   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      token     <= 3'b000;
      accepted  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state   <= stateNext;
      byte_rd <= 1'b0;
      done    <= 1'b0;
      rdPend  <= byte_rd;
      if (rdPend) prefetch <= byte_in;
      case (state)
        ST_IDLE: if (start) begin
          byte_rd   <= 1'b1;
          byte_addr <= '0;
          busy      <= 1'b1;
          token     <= 3'b000;
          accepted  <= 1'b0;
          timeout   <= 1'b0;
          cnt       <= '0;
          busyCnt   <= '0;
        end
        ST_PRE: if (sdclk_fall) begin
          dat0_oe <= 1'b1;
          dat0_o  <= 1'b1;
          cnt     <= (cnt == PRE_LAST) ? 12'd0 : cnt + 12'd1;
        end
        ST_START: if (sdclk_fall) dat0_o <= 1'b0;
        ST_DATA: if (sdclk_fall) begin
          dat0_o   <= dataBit;
          shiftReg <= loadByte ? {prefetch[6:0], 1'b0} : {shiftReg[6:0], 1'b0};
          if (loadByte) begin
            // address wraps to 0 after the last byte, but no read is issued for it
            byte_addr <= byteIdx + 9'd1;
            byte_rd   <= (byteIdx != BYTE_LAST);
          end
          cnt <= cnt + 12'd1;
        end
        ST_CRC: if (sdclk_fall) begin
          dat0_o <= crc[4'd15 - cnt[3:0]];
          cnt    <= (cnt == 12'd15) ? 12'd0 : cnt + 12'd1;
        end
        ST_END: if (sdclk_fall) dat0_o <= 1'b1;
        ST_TOKEN_WAIT: begin
          if (sdclk_fall) dat0_oe <= 1'b0;
          if (sdclk_rise) begin
            if (!dat0_i)             cnt     <= '0;
            else if (cnt == TOK_LAST) timeout <= 1'b1;
            else                     cnt     <= cnt + 12'd1;
          end
        end
        ST_TOKEN: if (sdclk_rise) begin
          if (cnt < 12'd3) token <= {token[1:0], dat0_i};
          cnt <= cnt + 12'd1;
        end
        ST_BUSY_WAIT: if (sdclk_rise && !dat0_i) begin
          if (busyCnt == BUSY_LAST) timeout <= 1'b1;
          else                      busyCnt <= busyCnt + 1'b1;
        end
        ST_FIN: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          accepted <= (token == TOK_ACCEPT) && !timeout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_writer.sv
// Directed bench for sd_block_writer: byte buffer, DAT0 pad and SD card models with immediate-assert checks.
// Latency: sdclk is two clk periods; fall and rise strobes alternate every clk.
// Backpressure: none; the buffer model answers every byte_rd one clk later.
module tb_sd_block_writer;

  logic       clk;
  logic       rstn;
  logic       sdclk_fall;
  logic       sdclk_rise;
  logic       start;
  logic [8:0] byte_addr;
  logic       byte_rd;
  logic [7:0] byte_in;
  logic       dat0_o;
  logic       dat0_oe;
  logic       dat0_i;
  logic       busy;
  logic       done;
  logic [2:0] token;
  logic       accepted;
  logic       timeout;

  sd_block_writer #(
    .PRE_BITS(8), .TOKEN_TIMEOUT(16), .BUSY_TIMEOUT(100), .BUSY_CNT_W(20)
  ) dut (
    .clk(clk), .rstn(rstn), .sdclk_fall(sdclk_fall), .sdclk_rise(sdclk_rise),
    .start(start), .byte_addr(byte_addr), .byte_rd(byte_rd), .byte_in(byte_in),
    .dat0_o(dat0_o), .dat0_oe(dat0_oe), .dat0_i(dat0_i), .busy(busy), .done(done),
    .token(token), .accepted(accepted), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int testCount = 0;
  int failCount = 0;

  logic [7:0]  mem [512];
  logic        phase;
  logic        pendRd;
  logic [8:0]  pendAddr;
  int          rdCount, rdAddrErrs, expAddr;
  int          doneCount;
  logic [2:0]  doneTok;
  logic        doneAcc, doneTo, doneBusy;
  int          rxPhase, preOnes, bitIdx, dataErrs;
  logic [15:0] crcModel, crcRx;
  logic        endBitOk;
  int          fallsSinceEnd, risesTok, risesBusy, glitchErrs;
  logic        prevO, prevOe;
  logic [2:0]  cardTok;
  logic        cardSilent, cardOe, cardVal;
  int          cardBusy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  task automatic resetMon();
    rdCount = 0; rdAddrErrs = 0; expAddr = 0; doneCount = 0;
    doneTok = 3'b000; doneAcc = 1'b0; doneTo = 1'b0; doneBusy = 1'b0;
    rxPhase = 0; preOnes = 0; bitIdx = 0; dataErrs = 0;
    crcModel = 16'h0000; crcRx = 16'h0000; endBitOk = 1'b0;
    fallsSinceEnd = 0; risesTok = 0; risesBusy = 0; glitchErrs = 0;
    cardOe = 1'b0; cardVal = 1'b1;
  endtask

  // Card receiver and responder, evaluated just after the DUT acted on a fall strobe
  task automatic fallEvent();
    logic [7:0] b;
    int sh;
    if (rxPhase == 0) begin
      if (dat0_oe) begin
        if (dat0_o) preOnes++;
        else begin rxPhase = 1; bitIdx = 0; end
      end
    end else if (rxPhase == 1) begin
      b  = mem[bitIdx / 8];
      sh = 7 - (bitIdx % 8);
      if (!dat0_oe || dat0_o !== b[sh]) dataErrs++;
      crcModel = crcStep(crcModel, b[sh]);
      bitIdx++;
      if (bitIdx == 4096) begin rxPhase = 2; bitIdx = 0; end
    end else if (rxPhase == 2) begin
      if (!dat0_oe) dataErrs++;
      crcRx = {crcRx[14:0], dat0_o};
      bitIdx++;
      if (bitIdx == 16) rxPhase = 3;
    end else if (rxPhase == 3) begin
      endBitOk = dat0_oe && dat0_o;
      rxPhase = 4;
      fallsSinceEnd = 0;
    end else begin
      fallsSinceEnd++;
      if (!cardSilent) begin
        if (fallsSinceEnd == 2) begin cardOe = 1'b1; cardVal = 1'b0; end
        else if (fallsSinceEnd >= 3 && fallsSinceEnd <= 5) cardVal = cardTok[5 - fallsSinceEnd];
        else if (fallsSinceEnd == 6) cardVal = 1'b1;
        else if (fallsSinceEnd >= 7 && fallsSinceEnd < 7 + cardBusy) cardVal = 1'b0;
        else if (fallsSinceEnd >= 7) cardOe = 1'b0;
      end
    end
  endtask

  // One clk: buffer model, monitors, card model, next strobe and pad value
  task automatic clkStep();
    @(negedge clk);
    if (pendRd) byte_in = mem[pendAddr];
    pendRd   = byte_rd;
    pendAddr = byte_addr;
    if (byte_rd) begin
      if (byte_addr !== expAddr[8:0]) rdAddrErrs++;
      expAddr++;
      rdCount++;
    end
    if (done) begin
      doneCount++;
      doneTok = token; doneAcc = accepted; doneTo = timeout; doneBusy = busy;
    end
    if (!sdclk_fall && (dat0_o !== prevO || dat0_oe !== prevOe)) glitchErrs++;
    prevO  = dat0_o;
    prevOe = dat0_oe;
    if (sdclk_fall) fallEvent();
    if (sdclk_rise && rxPhase == 4 && doneCount == 0) begin
      risesTok++;
      if (fallsSinceEnd >= 7) risesBusy++;
    end
    phase      = ~phase;
    sdclk_fall = phase;
    sdclk_rise = ~phase;
    dat0_i     = dat0_oe ? dat0_o : (cardOe ? cardVal : 1'b1);
  endtask

  task automatic runXfer(input string name, input logic incr, input logic [2:0] tok,
                         input logic silent, input int busyLen, input logic midStart,
                         input logic [2:0] expTok, input logic expAcc, input logic expTo,
                         input int expTokRises, input int expBusyRises);
    int budget;
    logic sawMid;
    for (int i = 0; i < 512; i++) mem[i] = incr ? 8'(i) : 8'hFF;
    resetMon();
    cardTok = tok; cardSilent = silent; cardBusy = busyLen;
    start = 1'b1;
    clkStep();
    start = 1'b0;
    check({name, ":busy_after_start"}, busy, 1);
    budget = 0;
    sawMid = 1'b0;
    while (doneCount == 0 && budget < 12000) begin
      if (midStart && !sawMid && rdCount == 100) begin
        start = 1'b1; clkStep(); start = 1'b0; sawMid = 1'b1;
      end else begin
        clkStep();
      end
      budget++;
    end
    repeat (20) clkStep();
    check({name, ":done_count"},   doneCount, 1);
    check({name, ":token"},        doneTok, expTok);
    check({name, ":accepted"},     doneAcc, expAcc);
    check({name, ":timeout"},      doneTo, expTo);
    check({name, ":busy_at_done"}, doneBusy, 0);
    check({name, ":pre_ones"},     preOnes, 8);
    check({name, ":rd_count"},     rdCount, 512);
    check({name, ":rd_addr_errs"}, rdAddrErrs, 0);
    check({name, ":data_errs"},    dataErrs, 0);
    check({name, ":crc"},          crcRx, crcModel);
    check({name, ":end_bit"},      endBitOk, 1);
    check({name, ":off_strobe_changes"}, glitchErrs, 0);
    check({name, ":oe_released"},  dat0_oe, 0);
    if (expTokRises >= 0)  check({name, ":token_wait_rises"}, risesTok, expTokRises);
    if (expBusyRises >= 0) check({name, ":busy_wait_rises"}, risesBusy, expBusyRises);
  endtask

  initial begin
    int budget;
    rstn = 1'b0; start = 1'b0; sdclk_fall = 1'b0; sdclk_rise = 1'b0;
    dat0_i = 1'b1; byte_in = 8'h00; phase = 1'b0; pendRd = 1'b0; pendAddr = '0;
    prevO = 1'b1; prevOe = 1'b0;
    cardTok = 3'b010; cardSilent = 1'b0; cardBusy = 40;
    resetMon();
    repeat (3) clkStep();
    check("reset:dat0_o",    dat0_o, 1);
    check("reset:dat0_oe",   dat0_oe, 0);
    check("reset:busy",      busy, 0);
    check("reset:done",      done, 0);
    check("reset:token",     token, 3'b000);
    check("reset:accepted",  accepted, 0);
    check("reset:timeout",   timeout, 0);
    check("reset:byte_rd",   byte_rd, 0);
    check("reset:byte_addr", byte_addr, 0);
    rstn = 1'b1;
    repeat (4) clkStep();

    runXfer("ff_accept", 1'b0, 3'b010, 1'b0, 40, 1'b0, 3'b010, 1'b1, 1'b0, -1, 41);
    check("ff_accept:crc_const", crcRx, 16'h7FA1);
    check("ff_accept:token_hold", token, 3'b010);
    check("ff_accept:accepted_hold", accepted, 1);

    runXfer("incr_midstart", 1'b1, 3'b010, 1'b0, 40, 1'b1, 3'b010, 1'b1, 1'b0, -1, 41);
    runXfer("crc_err_tok", 1'b1, 3'b101, 1'b0, 40, 1'b0, 3'b101, 1'b0, 1'b0, -1, 41);
    runXfer("no_token", 1'b0, 3'b010, 1'b1, 0, 1'b0, 3'b000, 1'b0, 1'b1, 16, -1);
    runXfer("busy_timeout", 1'b0, 3'b010, 1'b0, 1000, 1'b0, 3'b010, 1'b0, 1'b1, -1, 100);

    // Reset while transmitting byte 200
    for (int i = 0; i < 512; i++) mem[i] = 8'(i);
    resetMon();
    start = 1'b1;
    clkStep();
    start = 1'b0;
    budget = 0;
    while (rdCount < 201 && budget < 5000) begin
      clkStep();
      budget++;
    end
    check("rst_mid:reached_byte200", rdCount, 201);
    check("rst_mid:oe_before", dat0_oe, 1);
    rstn = 1'b0;
    #1;
    check("rst_mid:dat0_oe", dat0_oe, 0);
    check("rst_mid:dat0_o",  dat0_o, 1);
    check("rst_mid:busy",    busy, 0);
    check("rst_mid:byte_rd", byte_rd, 0);
    repeat (5) clkStep();
    rstn = 1'b1;
    repeat (40) clkStep();
    check("rst_mid:no_done",  doneCount, 0);
    check("rst_mid:idle_oe",  dat0_oe, 0);
    check("rst_mid:idle_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
